// File: rtl/seg_scan_display_if.sv
// Display-stage bundle: binary count and direction in, busy flag and
// multiplexed active-low seven-segment drive out.
interface seg_scan_display_if #(
    parameter int VAL_W = 8
);
    logic [VAL_W-1:0] value;
    logic             direction;
    logic             busy;
    logic [3:0]       an;
    logic [6:0]       seg;

    modport master (
        output value,
        output direction,
        input  busy,
        input  an,
        input  seg
    );

    modport slave (
        input  value,
        input  direction,
        output busy,
        output an,
        output seg
    );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: converts a binary count to three BCD digits with a
// sequential double-dabble engine, then scans four active-low 7-segment
// digits (direction glyph, hundreds, tens, ones) from a prescaler tick.
// Optional feature macro: SEG_SCAN_BLANK_EN enables leading-zero blanking.
module seg_scan_display #(
    parameter int VAL_W    = 8,
    parameter int SCAN_DIV = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_display_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(VAL_W - 1);
    localparam logic [SCAN_DIV-1:0] PRESC_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

    // Seven-segment pattern {a..g}, active-low, for one BCD digit.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would overflow on shift.
    function automatic logic [3:0] dabble(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

    state_t           r_state;
    logic [VAL_W-1:0] r_shift;
    logic [VAL_W-1:0] r_last;
    logic [11:0]      r_bcd;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic [3:0]       r_hund;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_dir;
    logic [SCAN_DIV-1:0] r_presc;
    logic [1:0]       r_idx;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    logic [11:0]      w_adj;
    logic             w_tick;
    logic [6:0]       w_hund_seg;
    logic [6:0]       w_tens_seg;
    logic [6:0]       w_ones_seg;

    assign bus.busy = r_busy;
    assign bus.an   = r_an;
    assign bus.seg  = r_seg;
    assign w_tick   = &r_presc;

    // Per-nibble add-3 correction applied before each shift.
    always_comb begin
        w_adj = {dabble(r_bcd[11:8]), dabble(r_bcd[7:4]), dabble(r_bcd[3:0])};
    end

    // Digit patterns from the committed display registers, with optional blanking.
    always_comb begin
        w_ones_seg = glyph(r_ones);
`ifdef SEG_SCAN_BLANK_EN
        if (r_hund == 4'd0) begin
            w_hund_seg = 7'b1111111;
        end else begin
            w_hund_seg = glyph(r_hund);
        end
        if ((r_hund == 4'd0) && (r_tens == 4'd0)) begin
            w_tens_seg = 7'b1111111;
        end else begin
            w_tens_seg = glyph(r_tens);
        end
`else
        w_hund_seg = glyph(r_hund);
        w_tens_seg = glyph(r_tens);
`endif
    end

    // Conversion FSM: latch a changed value, iterate VAL_W shifts, commit digits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_last  <= '0;
            r_bcd   <= 12'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.value != r_last) begin
                        r_shift <= bus.value;
                        r_last  <= bus.value;
                        r_bcd   <= 12'd0;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_bcd   <= {w_adj[10:0], r_shift[VAL_W-1]};
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    r_hund  <= r_bcd[11:8];
                    r_tens  <= r_bcd[7:4];
                    r_ones  <= r_bcd[3:0];
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Direction bypasses the converter and is simply registered every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dir <= 1'b0;
        end else begin
            r_dir <= bus.direction;
        end
    end

    // Free-running prescaler and digit scan; outputs hold between ticks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 2'd3;
            r_an    <= 4'b1111;
            r_seg   <= 7'b1111111;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
            if (w_tick) begin
                r_idx <= r_idx - 2'd1;
                case (r_idx)
                    2'd3: begin
                        r_an  <= 4'b0111;
                        r_seg <= r_dir ? 7'b0011101 : 7'b1100011;
                    end
                    2'd2: begin
                        r_an  <= 4'b1011;
                        r_seg <= w_hund_seg;
                    end
                    2'd1: begin
                        r_an  <= 4'b1101;
                        r_seg <= w_tens_seg;
                    end
                    2'd0: begin
                        r_an  <= 4'b1110;
                        r_seg <= w_ones_seg;
                    end
                    default: begin
                        r_an  <= 4'b1111;
                        r_seg <= 7'b1111111;
                    end
                endcase
            end else begin
                r_idx <= r_idx;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (VAL_W=8, SCAN_DIV=2).
module tb_seg_scan_display;
    localparam int VAL_W = 8;

`ifdef SEG_SCAN_BLANK_EN
    localparam logic [6:0] Z_LEAD = 7'b1111111;
`else
    localparam logic [6:0] Z_LEAD = 7'b0000001;
`endif
    localparam logic [6:0] G_UP   = 7'b0011101;
    localparam logic [6:0] G_DN   = 7'b1100011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [10:0] exp_q [$];

    seg_scan_display_if #(.VAL_W(VAL_W)) bus_if ();

    seg_scan_display #(.VAL_W(VAL_W), .SCAN_DIV(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        exp_q.push_back({4'b0111, s3});
        exp_q.push_back({4'b1011, s2});
        exp_q.push_back({4'b1101, s1});
        exp_q.push_back({4'b1110, s0});
    endtask

    task automatic wait_empty();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scan_drain: %0d slots never shown, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus_if.busy !== 1'b0 && k < 100) begin
            step();
            k++;
        end
        chk("busy_timeout", {31'd0, bus_if.busy}, 32'd0);
    endtask

    // Wait for the ones slot so the next tick starts a fresh frame, then queue it.
    task automatic expect_frame(input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0);
        int k = 0;
        @(negedge clk);
        while (bus_if.an !== 4'b1110 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("frame_sync", {28'd0, bus_if.an}, {28'd0, 4'b1110});
        @(posedge clk);
        push_frame(s3, s2, s1, s0);
        wait_empty();
    endtask

    task automatic chk_digits(input string name, input logic [3:0] h, input logic [3:0] t,
                              input logic [3:0] o);
        chk(name, {20'd0, dut.r_hund, dut.r_tens, dut.r_ones}, {20'd0, h, t, o});
    endtask

    // Monitor: every change of the anode pattern is one scan tick; compare it.
    initial begin
        logic [3:0]  prev_an = 4'b1111;
        logic [10:0] exp;
        forever begin
            @(negedge clk);
            if (bus_if.an !== prev_an) begin
                prev_an = bus_if.an;
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    chk("scan_slot", {21'd0, bus_if.an, bus_if.seg}, {21'd0, exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.value = 8'd0;
        bus_if.direction = 1'b1;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_an", {28'd0, bus_if.an}, {28'd0, 4'b1111});
            chk("rst_seg", {25'd0, bus_if.seg}, {25'd0, 7'b1111111});
            chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        end

        // Value 0, direction up: first tick 4 edges after release, two frames.
        push_frame(G_UP, Z_LEAD, Z_LEAD, 7'b0000001);
        push_frame(G_UP, Z_LEAD, Z_LEAD, 7'b0000001);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 3) chk("pre_tick_an", {28'd0, bus_if.an}, {28'd0, 4'b1111});
            if (k == 4) chk("first_tick_an", {28'd0, bus_if.an}, {28'd0, 4'b0111});
        end
        wait_empty();

        // 0 -> 255: busy for 9 cycles, digits commit at E0+9.
        bus_if.value = 8'd255;
        for (int i = 0; i <= 9; i++) begin
            step();
            chk("busy_255", {31'd0, bus_if.busy}, (i < 9) ? 32'd1 : 32'd0);
            if (i == 8) chk_digits("pre_commit_255", 4'd0, 4'd0, 4'd0);
            if (i == 9) chk_digits("commit_255", 4'd2, 4'd5, 4'd5);
        end
        expect_frame(G_UP, 7'b0010010, 7'b0100100, 7'b0100100);

        // 12 then 13 three cycles in: 12 commits, 13 starts right after.
        bus_if.value = 8'd12;
        bus_if.direction = 1'b0;
        for (int i = 0; i <= 19; i++) begin
            step();
            if (i == 3) bus_if.value = 8'd13;
            if (i == 9) begin
                chk_digits("commit_12", 4'd0, 4'd1, 4'd2);
                chk("busy_after_12", {31'd0, bus_if.busy}, 32'd0);
            end
            if (i == 10) chk("restart_13", {31'd0, bus_if.busy}, 32'd1);
            if (i == 19) chk_digits("commit_13", 4'd0, 4'd1, 4'd3);
        end
        expect_frame(G_DN, Z_LEAD, 7'b1001111, 7'b0000110);

        // Value 7, direction down: both leading zeros, ones never blanked.
        bus_if.value = 8'd7;
        step();
        wait_idle();
        expect_frame(G_DN, Z_LEAD, Z_LEAD, 7'b0001111);

        // Reset in the middle of converting 200, then reconvert after release.
        bus_if.value = 8'd200;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("midrst_an", {28'd0, bus_if.an}, {28'd0, 4'b1111});
        step();
        chk_digits("midrst_digits", 4'd0, 4'd0, 4'd0);
        rst_n = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            step();
            if (i == 0) chk("restart_200", {31'd0, bus_if.busy}, 32'd1);
            if (i == 9) begin
                chk_digits("commit_200", 4'd2, 4'd0, 4'd0);
                chk("busy_after_200", {31'd0, bus_if.busy}, 32'd0);
            end
        end
        expect_frame(G_DN, 7'b0010010, 7'b0000001, 7'b0000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
